rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised multi-write-port register file with per-register busy scoreboard, the next-generation integer register file for the RISC-V core. It provides two combinational read ports, two write ports (W0 = ALU writeback, W1 = late load/memory writeback), hardwired-zero register 0, and a busy bit per register that the decode stage sets at issue and writeback clears. A debug read port exposes any register to the board/monitor logic.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREG), register address width (derived; not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- A1, A2  in  AW  read addresses
- RD1, RD2  out  XLEN  read data
- busy1, busy2  out  1  scoreboard busy bit of A1 / A2
- W0En  in  1  write enable, port 0
- W0A  in  AW  write address, port 0
- W0D  in  XLEN  write data, port 0
- W1En  in  1  write enable, port 1
- W1A  in  AW  write address, port 1
- W1D  in  XLEN  write data, port 1
- sb_set  in  1  mark sb_addr busy (issue of an instruction writing sb_addr)
- sb_addr  in  AW  destination register being issued
- busy_any  out  1  OR of all busy bits
- debug_in  in  AW  debug read address
- debug_out  out  XLEN  debug read data (never bypassed)

## Operation
- Reset (rst_n low, asynchronous): registers 1..NREG-1 cleared to 0, all busy bits cleared; outputs settle combinationally to RD1=RD2=0, busy1=busy2=busy_any=0, debug_out=0. Reset asserted mid-write discards that write.
- Register 0: reads always 0, busy always 0; writes and sb_set to address 0 ignored.
- Write: on rising edge, WkEn with WkA≠0 stores WkD into rf[WkA].
- Dual-write collision (W0En, W1En, W0A==W1A≠0): W0 wins, W1 data dropped; both ports' clear effect still applies.
- Scoreboard: sb_set with sb_addr≠0 sets busy[sb_addr]; any write to address a clears busy[a]. Set and clear of the same address in one cycle: set wins (new producer). Set of already-busy register: stays busy (no counting).
- Read: RDk = rf[Ak] combinationally (0 for Ak=0). busyk = busy[Ak].
- Debug: debug_out = rf[debug_in], raw array value, no bypass.

## Timing
- Read latency 0 cycles (combinational from address).
- Write latency 1 cycle: data visible at RDk the cycle after the write edge (without bypass).
- Busy set visible on busyk the cycle after sb_set; clear visible the cycle after the write.
- No handshakes; every enable is single-cycle, one action per asserted cycle.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding. If W0En and W0A==Ak≠0, RDk=W0D; else if W1En and W1A==Ak≠0, RDk=W1D; else array value. busyk also reads 0 in the same cycle a write to Ak is presented, unless sb_set targets Ak that cycle. Read latency for written data becomes 0 cycles.
- RF_BYPASS_EN undefined: no forwarding; RDk and busyk reflect state as of the last edge only.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse rst_n low between edges -> RD1(A1=5)=0 immediately, busy_any=0.
- Zero reg: W0En, W0A=0, W0D=0x12345678, sb_set sb_addr=0 -> RD1(A1=0)=0, busy1=0 next cycle.
- Collision: W0 writes 0x11 and W1 writes 0x22 to r7 same edge -> RD2(A2=7)=0x11 next cycle.
- Scoreboard: sb_set r3; next cycle busy1(A1=3)=1, busy_any=1; W1 writes 0xAB to r3 -> next cycle busy1=0, RD1=0xAB; same-cycle sb_set r3 with W0 write r3 -> busy stays 1.
- Bypass: W0 writes 0xCAFE0001 to r9 with A1=9 same cycle -> RD1=0xCAFE0001 that cycle with RF_BYPASS_EN, old value without; debug_out(9) old value in both.
- Parameters: XLEN=64, NREG=16 -> write 0xFFFF_0000_FFFF_0000 to r15, read back exact 64-bit value; all 15 busy bits set/clear independently.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: two-read / two-write integer register file with a per-register busy scoreboard.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            busy1,
  output logic            busy2,
  input  logic            W0En,
  input  logic [AW-1:0]   W0A,
  input  logic [XLEN-1:0] W0D,
  input  logic            W1En,
  input  logic [AW-1:0]   W1A,
  input  logic [XLEN-1:0] W1D,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            busy_any,
  input  logic [AW-1:0]   debug_in,
  output logic [XLEN-1:0] debug_out
);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic w0_wr;
  logic w1_wr;
  logic sb_wr;

  assign w0_wr = W0En && (W0A != '0);
  assign w1_wr = W1En && (W1A != '0);
  assign sb_wr = sb_set && (sb_addr != '0);

  // Array update; W1 is applied first so W0 wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else begin
      if (w1_wr)
        rf[W1A] <= W1D;
      if (w0_wr)
        rf[W0A] <= W0D;
    end
  end

  // Next busy vector: writebacks clear, issue sets, a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (w0_wr)
      busy_nxt[W0A] = 1'b0;
    if (w1_wr)
      busy_nxt[W1A] = 1'b0;
    if (sb_wr)
      busy_nxt[sb_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  function automatic logic [XLEN-1:0] rd_mux(
    input logic [AW-1:0] a
  );
    logic [XLEN-1:0] v;
    v = rf[a];
`ifdef RF_BYPASS_EN
    if (w0_wr && (W0A == a))
      v = W0D;
    else if (w1_wr && (W1A == a))
      v = W1D;
`endif
    if (a == '0)
      v = '0;
    return v;
  endfunction

  function automatic logic busy_mux(
    input logic [AW-1:0] a
  );
    logic b;
    b = busy[a];
`ifdef RF_BYPASS_EN
    if (((w0_wr && (W0A == a)) || (w1_wr && (W1A == a)))
        && !(sb_wr && (sb_addr == a)))
      b = 1'b0;
`endif
    if (a == '0)
      b = 1'b0;
    return b;
  endfunction

  // Read ports, optionally forwarding same-cycle writeback.
  always_comb begin
    RD1   = rd_mux(A1);
    RD2   = rd_mux(A2);
    busy1 = busy_mux(A1);
    busy2 = busy_mux(A2);
  end

  // Status and raw debug view of the array.
  always_comb begin
    busy_any  = |busy;
    debug_out = (debug_in == '0) ? '0 : rf[debug_in];
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed and random checks of rf_scoreboard against a behavioural model.
// Also exercises a 64-bit / 16-entry instance.
module tb_rf_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2;
  logic [31:0] rd1, rd2;
  logic        busy1, busy2;
  logic        w0en, w1en, sb_set;
  logic [4:0]  w0a, w1a, sb_addr;
  logic [31:0] w0d, w1d;
  logic        busy_any;
  logic [4:0]  debug_in;
  logic [31:0] debug_out;

  logic [3:0]  wa1, wa2;
  logic [63:0] wrd1, wrd2;
  logic        wb1, wb2;
  logic        ww0en, ww1en, wsb;
  logic [3:0]  ww0a, ww1a, wsba;
  logic [63:0] ww0d, ww1d;
  logic        wbany;
  logic [3:0]  wdbg;
  logic [63:0] wdbo;

  int checks = 0;
  int passes = 0;

  logic [31:0] mrf [32];
  bit          mbusy [32];

  rf_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n),
    .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .busy1(busy1), .busy2(busy2),
    .W0En(w0en), .W0A(w0a), .W0D(w0d),
    .W1En(w1en), .W1A(w1a), .W1D(w1d),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_any(busy_any),
    .debug_in(debug_in), .debug_out(debug_out)
  );

  rf_scoreboard #(.XLEN(64), .NREG(16)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .A1(wa1), .A2(wa2), .RD1(wrd1), .RD2(wrd2),
    .busy1(wb1), .busy2(wb2),
    .W0En(ww0en), .W0A(ww0a), .W0D(ww0d),
    .W1En(ww1en), .W1A(ww1a), .W1D(ww1d),
    .sb_set(wsb), .sb_addr(wsba),
    .busy_any(wbany),
    .debug_in(wdbg), .debug_out(wdbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mrf[i]   = '0;
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (w0en && w0a == a) return w0d;
    if (w1en && w1a == a) return w1d;
`endif
    return mrf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (((w0en && w0a == a) || (w1en && w1a == a))
        && !(sb_set && sb_addr == a))
      return 1'b0;
`endif
    return mbusy[a];
  endfunction

  function automatic logic exp_any();
    for (int i = 1; i < 32; i++)
      if (mbusy[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge();
    if (w1en && w1a != 0) begin
      mrf[w1a]   = w1d;
      mbusy[w1a] = 1'b0;
    end
    if (w0en && w0a != 0) begin
      mrf[w0a]   = w0d;
      mbusy[w0a] = 1'b0;
    end
    if (sb_set && sb_addr != 0)
      mbusy[sb_addr] = 1'b1;
  endfunction

  task automatic check_outputs();
    #1;
    check("rd1", rd1, exp_rd(a1));
    check("rd2", rd2, exp_rd(a2));
    check("busy1", busy1, exp_busy(a1));
    check("busy2", busy2, exp_busy(a2));
    check("busy_any", busy_any, exp_any());
    check("debug", debug_out, mrf[debug_in]);
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    w0en = 1'b0;
    w1en = 1'b0;
    sb_set = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0)
      return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    a1 = 5; a2 = 0; debug_in = 5;
    w0en = 0; w0a = 0; w0d = 0;
    w1en = 0; w1a = 0; w1d = 0;
    sb_set = 0; sb_addr = 0;
    wa1 = 0; wa2 = 0; wdbg = 0;
    ww0en = 0; ww0a = 0; ww0d = 0;
    ww1en = 0; ww1a = 0; ww1d = 0;
    wsb = 0; wsba = 0;
    model_reset();
    #2;
    check_outputs();
    check("wide_rst_rd1", wrd1, 64'h0);
    check("wide_rst_any", wbany, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset clears state asynchronously and discards a write
    w0en = 1; w0a = 5; w0d = 32'hDEADBEEF;
    tick();
    sb_set = 1; sb_addr = 4;
    tick();
    #1;
    check("r5_written", rd1, 32'hDEADBEEF);
    check("busy_any_set", busy_any, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_rd1", rd1, 32'h0);
    check("rst_any", busy_any, 1'b0);
    w0en = 1; w0a = 5; w0d = 32'h5555AAAA;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0en = 0;
    #1;
    check("rst_discard", rd1, 32'h0);

    // register zero ignores writes and issue
    a1 = 0;
    w0en = 1; w0a = 0; w0d = 32'h12345678;
    sb_set = 1; sb_addr = 0;
    tick();
    #1;
    check("zero_rd1", rd1, 32'h0);
    check("zero_busy1", busy1, 1'b0);

    // dual-write collision: W0 wins
    a2 = 7;
    w0en = 1; w0a = 7; w0d = 32'h11;
    w1en = 1; w1a = 7; w1d = 32'h22;
    tick();
    #1;
    check("collide_rd2", rd2, 32'h11);

    // scoreboard set / clear / same-cycle set
    a1 = 3;
    sb_set = 1; sb_addr = 3;
    tick();
    #1;
    check("sb_busy1", busy1, 1'b1);
    check("sb_any", busy_any, 1'b1);
    w1en = 1; w1a = 3; w1d = 32'hAB;
    tick();
    #1;
    check("sb_clr_busy1", busy1, 1'b0);
    check("sb_clr_rd1", rd1, 32'hAB);
    sb_set = 1; sb_addr = 3;
    w0en = 1; w0a = 3; w0d = 32'h5;
    tick();
    #1;
    check("sb_setwins", busy1, 1'b1);

    // forwarding of a same-cycle write
    w0en = 1; w0a = 9; w0d = 32'h1111;
    tick();
    a1 = 9; debug_in = 9;
    w0en = 1; w0a = 9; w0d = 32'hCAFE0001;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_rd1", rd1, 32'hCAFE0001);
`else
    check("bypass_rd1", rd1, 32'h1111);
`endif
    check("bypass_dbg", debug_out, 32'h1111);
    tick();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      w0en = 1'($urandom); w0a = rnd_addr(); w0d = $urandom;
      w1en = 1'($urandom); w1a = rnd_addr(); w1d = $urandom;
      sb_set = 1'($urandom); sb_addr = rnd_addr();
      a1 = rnd_addr(); a2 = rnd_addr();
      debug_in = 5'($urandom);
      tick();
    end
    check_outputs();

    // 64-bit, 16-entry instance
    ww0en = 1; ww0a = 15; ww0d = 64'hFFFF_0000_FFFF_0000;
    wa1 = 15; wdbg = 15;
    @(posedge clk);
    #1;
    ww0en = 0;
    #1;
    check("wide_rd1", wrd1, 64'hFFFF_0000_FFFF_0000);
    check("wide_dbg", wdbo, 64'hFFFF_0000_FFFF_0000);
    for (int i = 1; i < 16; i++) begin
      wsb = 1; wsba = 4'(i);
      @(posedge clk);
      #1;
      wsb = 0;
      wa1 = 4'(i); wa2 = 4'(i + 1);
      #1;
      check("wide_set_b1", wb1, 1'b1);
      check("wide_set_b2", wb2, 1'b0);
      check("wide_set_any", wbany, 1'b1);
    end
    for (int i = 1; i < 16; i++) begin
      ww1en = 1; ww1a = 4'(i); ww1d = 64'(i) << 40;
      @(posedge clk);
      #1;
      ww1en = 0;
      wa1 = 4'(i); wa2 = 4'(i + 1);
      #1;
      check("wide_clr_b1", wb1, 1'b0);
      check("wide_clr_b2", wb2, i < 15);
      check("wide_clr_any", wbany, i < 15);
      check("wide_clr_rd1", wrd1, 64'(i) << 40);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
